// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style pipeline: reset PC and memory-port encodings.
package mips_pkg;

    localparam logic [31:0] START_ADDR = 32'h8002_0000;

    localparam logic [1:0] ACC_1W  = 2'b00;
    localparam logic [1:0] ACC_4W  = 2'b01;
    localparam logic [1:0] ACC_8W  = 2'b10;
    localparam logic [1:0] ACC_16W = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, insn} pairs; registered storage, combinational head.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A full buffer still accepts a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != FULL) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_valid = (count_q != '0);
    assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, credit-based read issue, response tracking and redirect flush.
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = mips_pkg::START_ADDR
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    output logic                  mem_enable,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    output logic [DATA_WIDTH-1:0] insn,
    output logic [ADDR_WIDTH-1:0] insn_pc
);
    import mips_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] ISSUE_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  resp_pending_q, resp_pending_d;
    logic                  drop_q, drop_d;

    logic                  pop, accept, fifo_push;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credit;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;
    logic                  unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign pop = insn_valid && insn_ready;
    // Slots already owed to the buffer: stored entries plus the word still in flight.
    assign credit = {1'b0, fifo_count} + {{CNT_W{1'b0}}, resp_pending_q}
                  - {{CNT_W{1'b0}}, pop};

    assign mem_enable      = !reset && !redirect_valid && (credit < ISSUE_LIMIT);
    assign accept          = mem_enable && !mem_busy;
    assign mem_address     = fetch_pc_q;
    assign mem_access_size = ACC_1W;
    assign mem_rw          = RW_READ;

    assign fifo_push = resp_pending_q && !drop_q && !redirect_valid;

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        resp_pending_d = accept;
        drop_d         = redirect_valid;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (accept) begin
            resp_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q     <= START_ADDR;
            resp_pc_q      <= '0;
            resp_pending_q <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            resp_pc_q      <= resp_pc_d;
            resp_pending_q <= resp_pending_d;
            drop_q         <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (fifo_push),
        .push_data  ({resp_pc_q, mem_data_out}),
        .pop        (pop),
        .head_valid (insn_valid),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    assign insn_pc = fifo_head[DATA_WIDTH +: ADDR_WIDTH];
    assign insn    = fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: behavioural memory, expected-PC queue, directed phases.
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [31:0] insn_pc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_pops   = 0;
    logic [31:0] sb_q[$];

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_access_size (mem_access_size),
        .mem_rw          (mem_rw),
        .mem_enable      (mem_enable),
        .mem_busy        (mem_busy),
        .mem_data_out    (mem_data_out),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .insn_valid      (insn_valid),
        .insn_ready      (insn_ready),
        .insn            (insn),
        .insn_pc         (insn_pc)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[23:16] ^ 8'hA5;
    endfunction

    // Big-endian: the byte at the lowest address is the most significant.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] p;
        sb_q.delete();
        p = pc;
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    // Memory: accept on enable && !busy, return the word during the next cycle.
    initial begin
        logic        acc;
        logic [31:0] addr;
        mem_data_out = 32'hDEAD_BEEF;
        forever begin
            @(posedge clock);
            acc  = mem_enable && !mem_busy;
            addr = mem_address;
            #1 mem_data_out = acc ? mem_word(addr) : 32'hDEAD_BEEF;
        end
    end

    // Consumer side: every handshake pops the next expected pc.
    initial begin
        logic [31:0] pc;
        forever begin
            @(negedge clock);
            if (!reset && !redirect_valid) begin
                if (dut.fifo_push && dut.fifo_count == 3'd4 && !(insn_valid && insn_ready))
                    check("fifo_overflow", 1, 0);
                if (insn_valid && insn_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_empty", 1, 0);
                    end else begin
                        pc = sb_q.pop_front();
                        check("insn_pc", insn_pc, pc);
                        check("insn", insn, mem_word(pc));
                        n_pops++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned p0;
        logic [31:0] addr0;
        bit          hit;

        reset          = 1'b1;
        mem_busy       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        insn_ready     = 1'b1;
        repeat (3) tick();

        @(negedge clock);
        check("rst_enable", mem_enable, 0);
        check("rst_address", mem_address, START);
        check("rst_valid", insn_valid, 0);
        check("rst_insn", insn, 0);
        check("rst_insn_pc", insn_pc, 0);
        check("rst_rw", mem_rw, 1);
        check("rst_size", mem_access_size, 0);

        // Release after edge E0; first instruction valid after E2.
        tick();
        reset = 1'b0;
        sb_restart(START);
        p0 = n_pops;
        @(negedge clock);
        check("lat_enable_e0", mem_enable, 1);
        @(negedge clock);
        check("lat_valid_e1", insn_valid, 0);
        @(negedge clock);
        check("lat_valid_e2", insn_valid, 1);
        repeat (8) tick();
        check("stream_progress", (n_pops - p0) >= 8, 1);

        // Busy for three cycles: address and enable held.
        tick();
        mem_busy = 1'b1;
        addr0    = mem_address;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("busy_addr_hold", mem_address, addr0);
            check("busy_enable_hold", mem_enable, 1);
        end
        tick();
        mem_busy = 1'b0;
        p0 = n_pops;
        repeat (8) tick();
        check("busy_progress", (n_pops - p0) >= 5, 1);

        // Decode stalls: buffer fills to depth, issue stops, head stays put.
        tick();
        insn_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (insn_valid) check("stall_head_pc", insn_pc, sb_q[0]);
        end
        check("stall_count", dut.fifo_count, 4);
        check("stall_enable", mem_enable, 0);
        check("stall_valid", insn_valid, 1);
        tick();
        insn_ready = 1'b1;
        p0 = n_pops;
        repeat (10) tick();
        check("stall_resume", (n_pops - p0) >= 8, 1);

        // Redirect with a response in flight; low address bits ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0103;
        sb_restart(32'h8002_0100);
        @(negedge clock);
        check("redir_enable", mem_enable, 0);
        check("redir_pending", dut.resp_pending_q, 1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("redir_valid_r0", insn_valid, 0);
        @(negedge clock);
        check("redir_valid_r1", insn_valid, 0);
        @(negedge clock);
        check("redir_valid_r2", insn_valid, 1);
        check("redir_pc_r2", insn_pc, 32'h8002_0100);
        repeat (6) tick();

        // Address wrap at the top of the space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        sb_restart(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        p0 = n_pops;
        repeat (8) tick();
        check("wrap_progress", (n_pops - p0) >= 4, 1);

        // Reset with a partially filled buffer.
        insn_ready = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (dut.fifo_count == 3'd3) hit = 1'b1;
        end
        check("buf3_reached", hit, 1);
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("mid_rst_valid", insn_valid, 0);
        check("mid_rst_address", mem_address, START);
        check("mid_rst_enable", mem_enable, 0);
        tick();
        reset      = 1'b0;
        insn_ready = 1'b1;
        sb_restart(START);
        p0 = n_pops;
        repeat (10) tick();
        check("restart_progress", (n_pops - p0) >= 7, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
